mips_mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory of the multi-cycle MIPS core with a host
//  (program loader / debug) port. Sits between the core's address/write-data mux outputs and

---
 rtl/mips_mem_arbiter_pkg.sv | 13 +
 rtl/mips_mem_arbiter_if.sv | 45 ++++
 rtl/mips_mem_arbiter_sat_counter.sv | 35 +++
 rtl/mips_mem_arbiter.sv | 108 ++++++++++
 tb/tb_mips_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types for the MIPS unified-memory arbiter: owner state encoding and
// statistics counter width.
package mem_arb_pkg;

  // Memory owner; the core owns the memory by default.
  typedef enum logic [0:0] {
    S_CORE = 1'b0,
    S_HOST = 1'b1
  } owner_e;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the MIPS core, the host port and Memory_System.
// The arbiter takes the slave view; the surrounding core/host/memory take master.
interface mips_mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_ack;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mips_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment unless saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing the multi-cycle MIPS core's unified memory with a host port.
// The core owns the memory by default; a pending host request is granted one
// access after at most MAX_CORE_RUN+1 cycles. core_stall freezes the core.
// Optional macro ARB_STATS_EN adds saturating host-grant / stall-cycle counters.
module mips_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_CORE_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  mips_mem_arbiter_if.slave bus,
  output logic [STAT_W-1:0] stat_host,
  output logic [STAT_W-1:0] stat_stall
);

  localparam int unsigned RunW = (MAX_CORE_RUN > 0) ? $clog2(MAX_CORE_RUN + 1) : 1;
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_CORE_RUN);

  owner_e          state_q, state_d;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  logic            host_sel;
  logic            host_ack_w;
  logic            core_stall_w;
  logic [AW-1:0]   addr_mux;
  logic [DW-1:0]   wdata_mux;

  // Owner next state and host wait counter.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    unique case (state_q)
      S_CORE: begin
        if (!bus.host_req) begin
          run_cnt_d = '0;
        end else if (bus.core_req && (run_cnt_q != RunMax)) begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
        if (bus.host_req && (!bus.core_req || (run_cnt_q == RunMax))) begin
          state_d   = S_HOST;
          run_cnt_d = '0;
        end
      end
      S_HOST: begin
        // One access per grant, so the core always gets the next cycle.
        state_d   = S_CORE;
        run_cnt_d = '0;
      end
    endcase
  end

  // Owner FSM and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_CORE;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Memory mux follows the registered owner; strobes are forced low during reset
  // so an access in flight is dropped without writing.
  always_comb begin
    host_sel     = (state_q == S_HOST);
    addr_mux     = host_sel ? bus.host_addr : bus.core_addr;
    wdata_mux    = host_sel ? bus.host_wdata : bus.core_wdata;
    host_ack_w   = reset & host_sel & bus.host_req;
    core_stall_w = reset & host_sel & bus.core_req;
    bus.mem_we   = reset & (host_sel ? (bus.host_we & bus.host_req) : bus.core_we);
  end

  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;
  assign bus.core_rdata = bus.mem_rdata;
  assign bus.host_rdata = bus.mem_rdata;
  assign bus.host_ack   = host_ack_w;
  assign bus.core_stall = core_stall_w;

`ifdef ARB_STATS_EN
  sat_counter #(
    .Width (STAT_W)
  ) u_stat_host (
    .clk_i   (clk),
    .rst_ni  (reset),
    .inc_i   (host_ack_w),
    .clear_i (1'b0),
    .count_o (stat_host)
  );

  sat_counter #(
    .Width (STAT_W)
  ) u_stat_stall (
    .clk_i   (clk),
    .rst_ni  (reset),
    .inc_i   (core_stall_w),
    .clear_i (1'b0),
    .count_o (stat_stall)
  );
`else
  assign stat_host  = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a small combinational-read memory model.
module tb_mips_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] stat_host;
  logic [15:0] stat_stall;
  logic [31:0] mem_model [0:255];
  int          checks;
  int          errors;
  int          we_pulses;

  mips_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mips_mem_arbiter #(
    .AW           (32),
    .DW           (32),
    .MAX_CORE_RUN (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stat_host  (stat_host),
    .stat_stall (stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory_System stand-in: combinational read, write at the rising edge.
  assign bus.mem_rdata = mem_model[bus.mem_addr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
    mem_model[0] = 32'h1234_5678;
    we_pulses = 0;
    forever begin
      @(posedge clk);
      if (bus.mem_we === 1'b1) begin
        mem_model[bus.mem_addr[9:2]] <= bus.mem_wdata;
        we_pulses++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_addr  = 32'h0040_0000;
    bus.core_wdata = 32'hFFFF_FFFF;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 32'h0;
    bus.host_wdata = 32'h0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we);
    end
    checks++;
    if (bus.host_ack !== 1'b0) begin
      errors++; $display("FAIL reset_host_ack: got %b expected 0", bus.host_ack);
    end
    checks++;
    if (bus.core_stall !== 1'b0) begin
      errors++; $display("FAIL reset_core_stall: got %b expected 0", bus.core_stall);
    end
    checks++;
    if (stat_host !== 16'h0 || stat_stall !== 16'h0) begin
      errors++; $display("FAIL reset_stats: got %h/%h expected 0/0", stat_host, stat_stall);
    end
    checks++;
    if (mem_model[0] !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_no_write: got %h expected 12345678", mem_model[0]);
    end
    bus.core_we = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_core_read();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.core_stall !== 1'b0) begin
        errors++; $display("FAIL core_read_stall c%0d: got %b expected 0", c, bus.core_stall);
      end
      checks++;
      if (bus.mem_addr !== 32'h0040_0000) begin
        errors++; $display("FAIL core_read_addr c%0d: got %h expected 00400000", c, bus.mem_addr);
      end
      checks++;
      if (bus.core_rdata !== 32'h1234_5678) begin
        errors++; $display("FAIL core_read_data c%0d: got %h expected 12345678", c,
                           bus.core_rdata);
      end
      tick();
    end
  endtask

  task automatic test_host_write();
    int start_pulses;
    bus.core_req   = 1'b0;
    bus.core_addr  = 32'h0040_0000;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 32'h0040_0010;
    bus.host_wdata = 32'hDEAD_BEEF;
    start_pulses   = we_pulses;
    @(negedge clk);
    checks++;
    if (bus.host_ack !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL host_write_cycle1: ack %b we %b expected 0 0", bus.host_ack,
                         bus.mem_we);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.host_ack !== 1'b1 || bus.mem_we !== 1'b1) begin
      errors++; $display("FAIL host_write_cycle2: ack %b we %b expected 1 1", bus.host_ack,
                         bus.mem_we);
    end
    checks++;
    if (bus.mem_addr !== 32'h0040_0010 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL host_write_bus: addr %h data %h expected 00400010 deadbeef",
                         bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.host_req  = 1'b0;
    bus.host_we   = 1'b0;
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h0040_0010;
    @(negedge clk);
    checks++;
    if (bus.host_ack !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL host_write_after: ack %b we %b expected 0 0", bus.host_ack,
                         bus.mem_we);
    end
    checks++;
    if (bus.core_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL host_write_readback: got %h expected deadbeef", bus.core_rdata);
    end
    checks++;
    if (we_pulses - start_pulses !== 1) begin
      errors++; $display("FAIL host_write_pulses: got %0d expected 1", we_pulses - start_pulses);
    end
    tick();
  endtask

  task automatic test_host_wait();
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_addr = 32'h0040_0000;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 32'h0040_0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.host_ack !== 1'b0 || bus.core_stall !== 1'b0) begin
        errors++; $display("FAIL host_wait_early c%0d: ack %b stall %b expected 0 0", c,
                           bus.host_ack, bus.core_stall);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.host_ack !== 1'b1 || bus.core_stall !== 1'b1) begin
      errors++; $display("FAIL host_wait_grant: ack %b stall %b expected 1 1", bus.host_ack,
                         bus.core_stall);
    end
    checks++;
    if (bus.host_rdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h0040_0010) begin
      errors++; $display("FAIL host_wait_read: data %h addr %h expected deadbeef 00400010",
                         bus.host_rdata, bus.mem_addr);
    end
    tick();
    bus.host_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.core_stall !== 1'b0 || bus.mem_addr !== 32'h0040_0000) begin
      errors++; $display("FAIL host_wait_release: stall %b addr %h expected 0 00400000",
                         bus.core_stall, bus.mem_addr);
    end
    tick();
  endtask

  task automatic test_abort();
    int start_pulses;
    bus.core_req   = 1'b0;
    bus.core_addr  = 32'h0040_0000;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 32'h0040_0020;
    bus.host_wdata = 32'hCAFE_F00D;
    start_pulses   = we_pulses;
    tick();
    bus.host_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0 || bus.host_ack !== 1'b0) begin
      errors++; $display("FAIL abort_strobes: we %b ack %b expected 0 0", bus.mem_we,
                         bus.host_ack);
    end
    checks++;
    if (bus.mem_addr !== 32'h0040_0020) begin
      errors++; $display("FAIL abort_owner: addr %h expected 00400020", bus.mem_addr);
    end
    tick();
    bus.host_we  = 1'b0;
    bus.core_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h0040_0000 || bus.core_stall !== 1'b0) begin
      errors++; $display("FAIL abort_back_to_core: addr %h stall %b expected 00400000 0",
                         bus.mem_addr, bus.core_stall);
    end
    checks++;
    if (mem_model[8] !== 32'h0 || we_pulses != start_pulses) begin
      errors++; $display("FAIL abort_no_write: mem %h pulses %0d expected 0 0", mem_model[8],
                         we_pulses - start_pulses);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int start_pulses;
    bus.core_req   = 1'b0;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 32'h0040_0030;
    bus.host_wdata = 32'h0BAD_F00D;
    start_pulses   = we_pulses;
    tick();
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1) begin
      errors++; $display("FAIL rst_mid_active: we %b expected 1", bus.mem_we);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.host_ack !== 1'b0) begin
      errors++; $display("FAIL rst_mid_strobes: we %b ack %b expected 0 0", bus.mem_we,
                         bus.host_ack);
    end
    tick();
    reset         = 1'b1;
    bus.host_req  = 1'b0;
    bus.host_we   = 1'b0;
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h0040_0000;
    @(negedge clk);
    checks++;
    if (mem_model[12] !== 32'h0 || we_pulses != start_pulses) begin
      errors++; $display("FAIL rst_mid_no_write: mem %h pulses %0d expected 0 0", mem_model[12],
                         we_pulses - start_pulses);
    end
    checks++;
    if (bus.mem_addr !== 32'h0040_0000 || bus.core_stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid_owner: addr %h stall %b expected 00400000 0",
                         bus.mem_addr, bus.core_stall);
    end
    tick();
  endtask

  task automatic test_stats();
    int acks;
    logic [15:0] exp_cnt;
`ifdef ARB_STATS_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    acks = 0;
    reset = 1'b0;
    tick();
    reset         = 1'b1;
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_addr = 32'h0040_0000;
    bus.host_we   = 1'b0;
    bus.host_addr = 32'h0040_0010;
    for (int a = 0; a < 3; a++) begin
      bool_wait: begin
        bus.host_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (bus.host_ack === 1'b1) begin
            acks++;
            break;
          end
          tick();
        end
        tick();
        bus.host_req = 1'b0;
        tick();
      end
    end
    checks++;
    if (acks != 3) begin
      errors++; $display("FAIL stats_acks: got %0d expected 3", acks);
    end
    @(negedge clk);
    checks++;
    if (stat_host !== exp_cnt) begin
      errors++; $display("FAIL stats_host: got %0d expected %0d", stat_host, exp_cnt);
    end
    checks++;
    if (stat_stall !== exp_cnt) begin
      errors++; $display("FAIL stats_stall: got %0d expected %0d", stat_stall, exp_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_core_read();
    test_host_write();
    test_host_wait();
    test_abort();
    test_reset_mid_write();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
